// File: rtl/token_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : token_arb_pkg
// Brief    : Shared state encoding, default run limit and counter sizing for
//            the token stream arbiter.
// Revision : 1.0
// ============================================================================
package token_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } token_arb_state_e;

    localparam int DEFAULT_MAX_RUN = 200;

    function automatic int cnt_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/token_doubler_core.sv
`default_nettype none
// ============================================================================
// Module   : token_doubler_core
// Brief    : Run/pending counters and doubled serial output for one stream.
// Revision : 1.0
// ============================================================================
module token_doubler_core
    import token_arb_pkg::*;
#(
    parameter int MAX_RUN = DEFAULT_MAX_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic token,
    input  logic drain,
    input  logic clear,
    output logic b,
    output logic pending_zero,
    output logic pending_le1,
    output logic abort
);

    localparam int            CW    = cnt_width(MAX_RUN);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_RUN);

    logic [CW-1:0] run;
    logic [CW-1:0] pending;
    logic          tok_one;

    assign tok_one      = token & ~drain & ~clear;
    assign abort        = tok_one & ((run == LIMIT) | (pending == LIMIT));
    assign pending_zero = (pending == '0);
    // A zero token leaves pending empty exactly when at most one is queued.
    assign pending_le1  = (pending <= CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b       <= 1'b0;
            run     <= '0;
            pending <= '0;
        end else if (clear || abort) begin
            b       <= 1'b0;
            run     <= '0;
            pending <= '0;
        end else if (tok_one) begin
            b       <= 1'b1;
            run     <= run + CW'(1);
            pending <= pending + CW'(1);
        end else begin
            run <= '0;
            if (!pending_zero) begin
                b       <= 1'b1;
                pending <= pending - CW'(1);
            end else begin
                b <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/token_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : token_stream_arbiter
// Brief    : Grants one serial requester at a time to the token doubler,
//            drains before release and quarantines overflowing requesters.
//            TOKEN_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Revision : 1.0
// ============================================================================
module token_stream_arbiter
    import token_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_RUN = DEFAULT_MAX_RUN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         a,
    output logic [N_REQ-1:0]         gnt,
    output logic                     b,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [N_REQ-1:0]         overflow
);

    localparam int OW = $clog2(N_REQ);

    token_arb_state_e state;
    logic [N_REQ-1:0] eligible;
    logic             any_eligible;
    logic [OW-1:0]    winner;
    logic             owner_req;
    logic             token;
    logic             core_pending_zero;
    logic             core_pending_le1;
    logic             core_abort;

    assign eligible     = req & ~overflow;
    assign any_eligible = |eligible;
    assign owner_req    = req[owner];
    assign token        = (state == STREAM) & owner_req & a[owner];

`ifdef TOKEN_ARB_ROUND_ROBIN_EN
    // Scan downward so the nearest index above the last owner overwrites last.
    always_comb begin
        winner = owner;
        for (int k = N_REQ; k >= 1; k--) begin
            if (eligible[(int'(owner) + k) % N_REQ]) begin
                winner = OW'((int'(owner) + k) % N_REQ);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = OW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            overflow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state <= STREAM;
                        gnt   <= N_REQ'(1) << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    // An overflowing token wins over a simultaneous req drop.
                    if (core_abort) begin
                        overflow[owner] <= 1'b1;
                        state           <= IDLE;
                        gnt             <= '0;
                        busy            <= 1'b0;
                    end else if (!owner_req) begin
                        if (core_pending_le1) begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (core_pending_zero) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    token_doubler_core #(
        .MAX_RUN (MAX_RUN)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .token        (token),
        .drain        (state == DRAIN),
        .clear        (state == IDLE),
        .b            (b),
        .pending_zero (core_pending_zero),
        .pending_le1  (core_pending_le1),
        .abort        (core_abort)
    );

endmodule
`default_nettype wire

// File: tb/tb_token_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_token_stream_arbiter
// Brief    : Randomised self-checking bench against a stream-level model.
// Revision : 1.0
// ============================================================================
module tb_token_stream_arbiter;

    localparam int N_REQ   = 4;
    localparam int MAX_RUN = 200;
    localparam int TMAX    = 700;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_REQ-1:0] req   = '0;
    logic [N_REQ-1:0] a     = '0;
    logic [N_REQ-1:0] gnt;
    logic             b;
    logic [1:0]       owner;
    logic             busy;
    logic [N_REQ-1:0] overflow;

    int               n_checks = 0;
    int               n_fail   = 0;
    bit               toks [N_REQ][TMAX];
    int               tlen [N_REQ];
    bit               obs_b [$];
    logic [N_REQ-1:0] m_ovf   = '0;
    int               m_owner = 0;

    token_stream_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req      (req),
        .a        (a),
        .gnt      (gnt),
        .b        (b),
        .owner    (owner),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N_REQ-1:0] elig);
`ifdef TOKEN_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N_REQ; k++)
            if (elig[(m_owner + k) % N_REQ]) return (m_owner + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++)
            if (elig[k]) return k;
`endif
        return -1;
    endfunction

    // Drives requester r's token list once it holds the grant, then the drop
    // and drain, predicting b and gnt from the pending/run arithmetic.
    task automatic serve(input int r);
        int               pend = 0;
        int               run  = 0;
        bit               ab   = 0;
        bit               eb;
        bit               eg;
        logic [N_REQ-1:0] onehot;
        onehot = N_REQ'(1) << r;
        obs_b.delete();
        for (int i = 0; i < tlen[r] && !ab; i++) begin
            a    = N_REQ'($urandom);
            a[r] = toks[r][i];
            if (toks[r][i] && (run == MAX_RUN || pend == MAX_RUN)) begin
                ab       = 1;
                eb       = 0;
                m_ovf[r] = 1'b1;
            end else if (toks[r][i]) begin
                pend++;
                run++;
                eb = 1;
            end else begin
                run = 0;
                eb  = (pend > 0);
                if (pend > 0) pend--;
            end
            tick();
            obs_b.push_back(b);
            chk("b_stream", b, eb);
            chk("gnt_stream", gnt, ab ? 0 : onehot);
        end
        req[r] = 1'b0;
        if (ab) begin
            chk("overflow_set", overflow, m_ovf);
            chk("busy_abort", busy, 0);
        end else begin
            eb = (pend > 0);
            if (pend > 0) pend--;
            eg = (pend > 0);
            a  = N_REQ'($urandom);
            tick();
            chk("b_drop", b, eb);
            chk("gnt_drop", gnt, eg ? onehot : 0);
            for (int c = 0; c < MAX_RUN + 2 && eg; c++) begin
                eb = (pend > 0);
                eg = (pend > 0);
                if (pend > 0) pend--;
                a = N_REQ'($urandom);
                tick();
                chk("b_drain", b, eb);
                chk("gnt_drain", gnt, eg ? onehot : 0);
            end
            chk("busy_release", busy, 0);
        end
        a = '0;
    endtask

    // Raises req for mask and checks every grant decision until none remain.
    task automatic session(input logic [N_REQ-1:0] mask, input bit rereq, input int max_grants);
        logic [N_REQ-1:0] active;
        int               w;
        active = mask;
        req    = mask;
        for (int g = 0; g < max_grants; g++) begin
            tick();
            w = pick(active & ~m_ovf);
            if (w < 0) begin
                for (int k = 0; k < 3; k++) begin
                    chk("gnt_none", gnt, 0);
                    chk("busy_none", busy, 0);
                    if (k < 2) tick();
                end
                break;
            end
            m_owner = w;
            chk("gnt_grant", gnt, N_REQ'(1) << w);
            chk("owner", owner, w);
            chk("busy_grant", busy, 1);
            serve(w);
            active[w] = 1'b0;
            if (rereq && !m_ovf[w]) begin
                active[w] = 1'b1;
                req[w]    = 1'b1;
            end
        end
        req = '0;
    endtask

    task automatic rand_toks(input int r, input int maxlen);
        int dens;
        tlen[r] = $urandom_range(1, maxlen);
        dens    = $urandom_range(1, 3);
        for (int i = 0; i < tlen[r]; i++) toks[r][i] = ($urandom_range(0, 3) < dens);
    endtask

    initial begin
        logic [25:0] pat_a;
        logic [25:0] pat_b;
        logic [25:0] got26;
        pat_a = 26'b10010011000110100001100100;
        pat_b = 26'b11011011110111111001111110;

        #2 rst_n = 1'b0;
        #20;
        chk("rst_gnt", gnt, 0);
        chk("rst_b", b, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // Directed doubling pattern on requester 0
        tlen[0] = 26;
        for (int i = 0; i < 26; i++) toks[0][i] = pat_a[25-i];
        session(4'b0001, 0, 1);
        got26 = '0;
        for (int i = 0; i < 26 && i < obs_b.size(); i++) got26[25-i] = obs_b[i];
        chk("pattern26_b", got26, pat_b);

        // Requesters 1 and 2 together, three ones each
        for (int r = 1; r <= 2; r++) begin
            tlen[r] = 3;
            for (int i = 0; i < 3; i++) toks[r][i] = 1'b1;
        end
        session(4'b0110, 0, 4);

        // Random contention rounds
        for (int s = 0; s < 12; s++) begin
            for (int r = 0; r < N_REQ; r++) rand_toks(r, 24);
            session(N_REQ'($urandom_range(1, 15)), (s % 3) == 0, 7);
        end

        // Run-length overflow on requester 0
        tlen[0] = 201;
        for (int i = 0; i < 201; i++) toks[0][i] = 1'b1;
        session(4'b0001, 0, 2);

        // Pending overflow on requester 3 via 110 repeats
        tlen[3] = TMAX;
        for (int i = 0; i < TMAX; i++) toks[3][i] = (i % 3) != 2;
        session(4'b1000, 0, 1);

        // Quarantined 0 and 3 keep requesting; 1 and 2 still served
        rand_toks(1, 10);
        rand_toks(2, 10);
        session(4'b1111, 0, 6);

        // Reset in the middle of a drain
        req[1] = 1'b1;
        tick();
        chk("rd_gnt", gnt, 4'b0010);
        for (int i = 0; i < 13; i++) begin
            a[1] = 1'b1;
            tick();
            chk("rd_b_stream", b, 1);
        end
        req[1] = 1'b0;
        a      = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rd_b_drain", b, 1);
        end
        chk("rd_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rd_b", b, 0);
        chk("rd_gnt_low", gnt, 0);
        chk("rd_busy", busy, 0);
        chk("rd_owner", owner, 0);
        chk("rd_overflow", overflow, 0);
        m_ovf   = '0;
        m_owner = 0;
        #3 rst_n = 1'b1;

        rand_toks(2, 16);
        session(4'b0100, 0, 2);

        // Back-to-back contention between 0 and 3
        for (int r = 0; r < N_REQ; r++) rand_toks(r, 8);
        session(4'b1001, 1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
